regfile_wb_sequencer: RTL and testbench
=======================================

Name: regfile_wb_sequencer

Overview:
- Write-side sequencer for the 32x32 register file. It is the only block allowed to drive the file's write port (we/wsel/data).
- Merges two result sources into that single port:
  - single-cycle ALU results, via a valid/ready handshake;
  - multi-cycle load results, which return in order after their destination register was reserved at issue.
- Keeps a per-register pending scoreboard so the operand-read stage can stall on registers that still await a load.

Parameters:
- DEPTH, 4, maximum outstanding loads; load queue entries; power of two, at least 2.
- DATA_W, 32, result and register data width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset; clock clk
- alu_valid  in  1  ALU result offered
- alu_ready  out  1  ALU result accepted this cycle when alu_valid && alu_ready
- alu_wsel  in  5  ALU destination register
- alu_data  in  DATA_W  ALU result
- ld_req_valid  in  1  load issue request, reserves a destination
- ld_req_ready  out  1  issue accepted when ld_req_valid && ld_req_ready
- ld_req_wsel  in  5  load destination register
- ld_rsp_valid  in  1  load data return, in issue order, always accepted
- ld_rsp_data  in  DATA_W  load data
- we  out  1  register file write enable
- wsel  out  5  register file write select
- data  out  DATA_W  register file write data
- pending  out  32  bit r set while a load to register r is outstanding; bit 0 always 0
- rsp_err  out  1  one-cycle pulse when ld_rsp_valid arrives with no unfilled entry

Behaviour:
- Load queue: circular buffer of DEPTH entries {wsel, data, filled}, with head/tail pointers and a count.
  - Accepted issue pushes {ld_req_wsel, x, 0} at the tail.
  - ld_rsp_valid fills the oldest unfilled entry.
- ld_req_ready = (count < DEPTH) && !pending[ld_req_wsel].
  - A second load to a register that is already pending is refused.
  - Issue to r0 is allowed; it does not set pending, and its commit produces we=0.
- Commit arbitration, one write per cycle:
  - head_full = (count==DEPTH) && head.filled.
  - If head_full: commit the head and hold alu_ready=0.
  - Otherwise: alu_ready=1. An ALU handshake commits the ALU result; if there is no ALU handshake and head.filled, commit the head.
- Output timing: registered. we/wsel/data update on the clock edge that performs the commit, giving 1-cycle latency from handshake or fill to the write appearing.
  - we=0 in cycles with no commit; wsel/data hold their last values.
  - A commit with wsel==0 forces we=0.
- Fill-to-commit: a response that fills the head entry in cycle N can commit at edge N+1 at the earliest. There is no same-cycle fill-and-commit.
- Scoreboard:
  - pending[r] sets on the edge that accepts an issue to r≠0.
  - pending[r] clears on the edge where that entry commits, i.e. the same edge we rises for r.
  - Simultaneous set and clear of the same r cannot occur, because issue is refused while r is pending.
- Queue pointers wrap modulo DEPTH.
  - Same-cycle issue and commit leaves count unchanged.
  - Same-cycle issue, fill and commit is legal.
- ALU write to a register with pending set: the ALU value is written, and the later load commit overwrites it. The decoder must not generate this case; the block does not check for it.
- rsp_err: raised when ld_rsp_valid arrives with every entry filled or the queue empty. The data is dropped and the pulse is registered, 1 cycle.
- Reset:
  - we=0, wsel=0, data=0, pending=0, rsp_err=0; queue emptied.
  - In-flight loads are discarded, so responses arriving after reset raise rsp_err.

Optional Feature:
- REGFILE_WB_BYPASS_EN defined adds these ports:
  - inputs byp_r1sel[4:0] and byp_r2sel[4:0];
  - outputs byp1_hit, byp1_data, byp2_hit, byp2_data.
- Hit rule: bypx_hit = we && (wsel == byp_rxsel) && (wsel != 0), combinational from the registered outputs; bypx_data = data. This lets the read stage see a value on the same cycle it is being written.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- ALU only: alu_valid, wsel=5, data=0x1234 for 1 cycle -> next cycle we=1, wsel=5, data=0x1234; the following cycle we=0.
- Load round trip: issue wsel=8 -> pending[8]=1; response 0xCAFE two cycles later -> we=1, wsel=8, data=0xCAFE one cycle after the response, and pending[8]=0 on that same edge.
- Backpressure and full: issue loads to r1-r4 (DEPTH=4) and ld_req_ready drops; fill all four with alu_valid held -> alu_ready=0 and the head commits r1 ahead of the ALU; count drops to 3 and alu_ready returns to 1.
- Duplicate/zero: issue r9 then r9 again -> second refused (ld_req_ready=0); ALU write to r0 -> handshake completes, we stays 0.
- Error/reset: 2 loads outstanding, assert reset for 1 cycle -> pending=0, we=0; then ld_rsp_valid -> rsp_err pulses for 1 cycle and no write occurs.
- Bypass (macro defined): ALU write r12=0x55 and byp_r1sel=12 in the commit cycle -> byp1_hit=1, byp1_data=0x55; byp_r2sel=0 -> byp2_hit=0.

Source files
------------

// File: rtl/regfile_wb_sequencer.sv
// Write-side sequencer for the 32x32 register file: merges ALU results and in-order load returns onto one write port.
// Optional same-cycle read bypass ports are built when REGFILE_WB_BYPASS_EN is defined.
module regfile_wb_sequencer #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [4:0]        alu_wsel,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              ld_req_valid,
    output logic              ld_req_ready,
    input  logic [4:0]        ld_req_wsel,
    input  logic              ld_rsp_valid,
    input  logic [DATA_W-1:0] ld_rsp_data,
    output logic              we,
    output logic [4:0]        wsel,
    output logic [DATA_W-1:0] data,
    output logic [31:0]       pending,
    output logic              rsp_err
`ifdef REGFILE_WB_BYPASS_EN
    ,
    input  logic [4:0]        byp_r1sel,
    input  logic [4:0]        byp_r2sel,
    output logic              byp1_hit,
    output logic [DATA_W-1:0] byp1_data,
    output logic              byp2_hit,
    output logic [DATA_W-1:0] byp2_data
`endif
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [4:0]        r_q_wsel [DEPTH];
    logic [DATA_W-1:0] r_q_data [DEPTH];
    logic [DEPTH-1:0]  r_q_filled;
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [PTR_W-1:0]  r_fill_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  r_unfilled;
    logic [31:0]       r_pending;
    logic              r_we;
    logic [4:0]        r_wsel;
    logic [DATA_W-1:0] r_data;
    logic              r_rsp_err;

    logic              w_full;
    logic              w_head_filled;
    logic              w_head_force;
    logic              w_alu_hs;
    logic              w_ld_hs;
    logic              w_commit_head;
    logic              w_commit;
    logic              w_fill;
    logic              w_err;
    logic [4:0]        w_cm_sel;
    logic [DATA_W-1:0] w_cm_data;
    logic [31:0]       w_pend_set;
    logic [31:0]       w_pend_clr;

    // Arbitration, handshakes and scoreboard update vectors
    always_comb begin
        w_full        = (r_count == CNT_W'(DEPTH));
        w_head_filled = (r_count != {CNT_W{1'b0}}) && r_q_filled[r_head];
        w_head_force  = w_full && w_head_filled;
        alu_ready     = !w_head_force;
        ld_req_ready  = !w_full && !r_pending[ld_req_wsel];
        w_alu_hs      = alu_valid && alu_ready;
        w_ld_hs       = ld_req_valid && ld_req_ready;
        // A full queue with a ready head would deadlock issue, so it beats the ALU
        w_commit_head = w_head_force || (!w_alu_hs && w_head_filled);
        w_commit      = w_commit_head || w_alu_hs;
        w_fill        = ld_rsp_valid && (r_unfilled != {CNT_W{1'b0}});
        w_err         = ld_rsp_valid && (r_unfilled == {CNT_W{1'b0}});
        if (w_commit_head) begin
            w_cm_sel   = r_q_wsel[r_head];
            w_cm_data  = r_q_data[r_head];
            w_pend_clr = 32'd1 << r_q_wsel[r_head];
        end else begin
            w_cm_sel   = alu_wsel;
            w_cm_data  = alu_data;
            w_pend_clr = 32'd0;
        end
        if (w_ld_hs && (ld_req_wsel != 5'd0)) begin
            w_pend_set = 32'd1 << ld_req_wsel;
        end else begin
            w_pend_set = 32'd0;
        end
    end

    // Queue payload storage; contents are only meaningful while counted
    always_ff @(posedge clk) begin
        if (w_ld_hs) begin
            r_q_wsel[r_tail] <= ld_req_wsel;
        end
        if (w_fill) begin
            r_q_data[r_fill_ptr] <= ld_rsp_data;
        end
    end

    // Queue control: pointers, counts and filled flags
    always_ff @(posedge clk) begin
        if (reset) begin
            r_head     <= {PTR_W{1'b0}};
            r_tail     <= {PTR_W{1'b0}};
            r_fill_ptr <= {PTR_W{1'b0}};
            r_count    <= {CNT_W{1'b0}};
            r_unfilled <= {CNT_W{1'b0}};
            r_q_filled <= {DEPTH{1'b0}};
        end else begin
            if (w_commit_head) begin
                r_q_filled[r_head] <= 1'b0;
                r_head             <= r_head + PTR_W'(1);
            end
            if (w_fill) begin
                r_q_filled[r_fill_ptr] <= 1'b1;
                r_fill_ptr             <= r_fill_ptr + PTR_W'(1);
            end
            if (w_ld_hs) begin
                r_q_filled[r_tail] <= 1'b0;
                r_tail             <= r_tail + PTR_W'(1);
            end
            if (w_ld_hs && !w_commit_head) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_ld_hs && w_commit_head) begin
                r_count <= r_count - CNT_W'(1);
            end
            if (w_ld_hs && !w_fill) begin
                r_unfilled <= r_unfilled + CNT_W'(1);
            end else if (!w_ld_hs && w_fill) begin
                r_unfilled <= r_unfilled - CNT_W'(1);
            end
        end
    end

    // Registered write port, scoreboard and error pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            r_we      <= 1'b0;
            r_wsel    <= 5'd0;
            r_data    <= {DATA_W{1'b0}};
            r_pending <= 32'd0;
            r_rsp_err <= 1'b0;
        end else begin
            r_we      <= w_commit && (w_cm_sel != 5'd0);
            r_rsp_err <= w_err;
            r_pending <= ((r_pending & ~w_pend_clr) | w_pend_set) & ~32'd1;
            if (w_commit) begin
                r_wsel <= w_cm_sel;
                r_data <= w_cm_data;
            end
        end
    end

    assign we      = r_we;
    assign wsel    = r_wsel;
    assign data    = r_data;
    assign pending = r_pending;
    assign rsp_err = r_rsp_err;

`ifdef REGFILE_WB_BYPASS_EN
    assign byp1_hit  = r_we && (r_wsel == byp_r1sel) && (r_wsel != 5'd0);
    assign byp2_hit  = r_we && (r_wsel == byp_r2sel) && (r_wsel != 5'd0);
    assign byp1_data = r_data;
    assign byp2_data = r_data;
`else
    // Without bypass the read stage sees a write only after the file updates
`endif

endmodule

// File: tb/tb_regfile_wb_sequencer.sv
// Self-checking bench for regfile_wb_sequencer: directed test-plan sequences plus randomized traffic
// compared every cycle against a queue-based reference model.
module tb_regfile_wb_sequencer;

    localparam int DEPTH  = 4;
    localparam int DATA_W = 32;

    logic              clk;
    logic              reset;
    logic              alu_valid;
    logic              alu_ready;
    logic [4:0]        alu_wsel;
    logic [DATA_W-1:0] alu_data;
    logic              ld_req_valid;
    logic              ld_req_ready;
    logic [4:0]        ld_req_wsel;
    logic              ld_rsp_valid;
    logic [DATA_W-1:0] ld_rsp_data;
    logic              we;
    logic [4:0]        wsel;
    logic [DATA_W-1:0] data;
    logic [31:0]       pending;
    logic              rsp_err;
`ifdef REGFILE_WB_BYPASS_EN
    logic [4:0]        byp_r1sel;
    logic [4:0]        byp_r2sel;
    logic              byp1_hit;
    logic [DATA_W-1:0] byp1_data;
    logic              byp2_hit;
    logic [DATA_W-1:0] byp2_data;
`endif

    regfile_wb_sequencer #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .alu_valid    (alu_valid),
        .alu_ready    (alu_ready),
        .alu_wsel     (alu_wsel),
        .alu_data     (alu_data),
        .ld_req_valid (ld_req_valid),
        .ld_req_ready (ld_req_ready),
        .ld_req_wsel  (ld_req_wsel),
        .ld_rsp_valid (ld_rsp_valid),
        .ld_rsp_data  (ld_rsp_data),
        .we           (we),
        .wsel         (wsel),
        .data         (data),
        .pending      (pending),
        .rsp_err      (rsp_err)
`ifdef REGFILE_WB_BYPASS_EN
        ,
        .byp_r1sel    (byp_r1sel),
        .byp_r2sel    (byp_r2sel),
        .byp1_hit     (byp1_hit),
        .byp1_data    (byp1_data),
        .byp2_hit     (byp2_hit),
        .byp2_data    (byp2_data)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  wsel;
        logic [31:0] data;
        bit          filled;
    } ent_t;

    ent_t        mq[$];
    bit   [31:0] m_pend;
    bit          m_we;
    logic [4:0]  m_wsel;
    logic [31:0] m_data;
    bit          m_err;

    int n_cmp;
    int n_bad;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: drive, check readies, advance model, check registered outputs
    task automatic cycle(input bit rst, input bit av, input logic [4:0] as, input logic [31:0] ad,
                         input bit lv, input logic [4:0] ls, input bit rv, input logic [31:0] rd);
        int   n;
        bit   hf;
        bit   force_head;
        bit   exp_ar;
        bit   exp_lr;
        bit   alu_hs;
        bit   ld_hs;
        bit   do_head;
        bit   cm;
        int   idx;
        logic [4:0]  sel;
        logic [31:0] d;
        reset        = rst;
        alu_valid    = av;
        alu_wsel     = as;
        alu_data     = ad;
        ld_req_valid = lv;
        ld_req_wsel  = ls;
        ld_rsp_valid = rv;
        ld_rsp_data  = rd;
        #1;
        n          = mq.size();
        hf         = (n > 0) && mq[0].filled;
        force_head = (n == DEPTH) && hf;
        exp_ar     = !force_head;
        exp_lr     = (n < DEPTH) && !m_pend[ls];
        if (!rst) begin
            check_eq("alu_ready", {63'd0, alu_ready}, {63'd0, exp_ar});
            check_eq("ld_req_ready", {63'd0, ld_req_ready}, {63'd0, exp_lr});
        end
        if (rst) begin
            mq.delete();
            m_pend = 32'd0;
            m_we   = 1'b0;
            m_wsel = 5'd0;
            m_data = 32'd0;
            m_err  = 1'b0;
        end else begin
            alu_hs  = av && exp_ar;
            ld_hs   = lv && exp_lr;
            do_head = force_head || (!alu_hs && hf);
            cm      = do_head || alu_hs;
            sel     = do_head ? mq[0].wsel : as;
            d       = do_head ? mq[0].data : ad;
            idx     = -1;
            for (int i = 0; i < n; i++) begin
                if (!mq[i].filled && idx < 0) idx = i;
            end
            if (rv && idx >= 0) begin
                mq[idx].data   = rd;
                mq[idx].filled = 1'b1;
            end
            if (do_head) begin
                m_pend[sel] = 1'b0;
                void'(mq.pop_front());
            end
            if (ld_hs) begin
                mq.push_back('{wsel: ls, data: 32'd0, filled: 1'b0});
                if (ls != 5'd0) m_pend[ls] = 1'b1;
            end
            m_we  = cm && (sel != 5'd0);
            m_err = rv && (idx < 0);
            if (cm) begin
                m_wsel = sel;
                m_data = d;
            end
        end
        @(posedge clk);
        @(negedge clk);
        check_eq("we", {63'd0, we}, {63'd0, m_we});
        check_eq("wsel", {59'd0, wsel}, {59'd0, m_wsel});
        check_eq("data", {32'd0, data}, {32'd0, m_data});
        check_eq("pending", {32'd0, pending}, {32'd0, m_pend});
        check_eq("rsp_err", {63'd0, rsp_err}, {63'd0, m_err});
`ifdef REGFILE_WB_BYPASS_EN
        byp_r1sel = 5'($urandom_range(0, 31));
        byp_r2sel = 5'($urandom_range(0, 31));
        if ($urandom_range(0, 1) == 0) byp_r1sel = m_wsel;
        #1;
        check_eq("byp1_hit", {63'd0, byp1_hit}, {63'd0, m_we && (m_wsel == byp_r1sel) && (m_wsel != 5'd0)});
        check_eq("byp2_hit", {63'd0, byp2_hit}, {63'd0, m_we && (m_wsel == byp_r2sel) && (m_wsel != 5'd0)});
        if (m_we) check_eq("byp1_data", {32'd0, byp1_data}, {32'd0, m_data});
`endif
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 32'd0);
    endtask

    initial begin
        n_cmp  = 0;
        n_bad  = 0;
        m_pend = 32'd0;
        reset = 1'b1; alu_valid = 1'b0; alu_wsel = 5'd0; alu_data = 32'd0;
        ld_req_valid = 1'b0; ld_req_wsel = 5'd0; ld_rsp_valid = 1'b0; ld_rsp_data = 32'd0;
`ifdef REGFILE_WB_BYPASS_EN
        byp_r1sel = 5'd0; byp_r2sel = 5'd0;
`endif
        @(negedge clk);
        cycle(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 32'd0);
        check_eq("reset_we", {63'd0, we}, 64'd0);
        check_eq("reset_pending", {32'd0, pending}, 64'd0);

        // ALU only
        cycle(1'b0, 1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 1'b0, 32'd0);
        check_eq("alu_we", {63'd0, we}, 64'd1);
        check_eq("alu_data", {32'd0, data}, 64'h1234);
        idle(1);
        check_eq("alu_we_drop", {63'd0, we}, 64'd0);

        // Load round trip
        cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 1'b0, 32'd0);
        check_eq("ld_pend8", {63'd0, pending[8]}, 64'd1);
        idle(2);
        cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 32'hCAFE);
        idle(1);
        check_eq("ld_commit_data", {32'd0, data}, 64'hCAFE);
        check_eq("ld_pend8_clr", {63'd0, pending[8]}, 64'd0);

        // Fill the queue, then race the ALU against a full ready head
        for (int r = 1; r <= 4; r++) cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'(r), 1'b0, 32'd0);
        cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 1'b0, 32'd0);
        for (int r = 1; r <= 4; r++) cycle(1'b0, 1'b1, 5'd20, 32'h77, 1'b0, 5'd0, 1'b1, 32'(r * 32'h100));
        for (int r = 0; r < 6; r++) cycle(1'b0, 1'b1, 5'd21, 32'(r), 1'b0, 5'd0, 1'b0, 32'd0);
        idle(4);

        // Duplicate issue and r0 writes
        cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 1'b0, 32'd0);
        cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 1'b0, 32'd0);
        cycle(1'b0, 1'b1, 5'd0, 32'hDEAD, 1'b1, 5'd0, 1'b1, 32'h99);
        cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 32'h0);
        idle(3);

        // Reset with loads in flight, then a stray response
        cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd10, 1'b0, 32'd0);
        cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd11, 1'b0, 32'd0);
        cycle(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 32'd0);
        cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 32'h5);
        check_eq("stray_err", {63'd0, rsp_err}, 64'd1);
        idle(1);
        check_eq("stray_err_pulse", {63'd0, rsp_err}, 64'd0);

        // ALU write to r12 for the bypass path
        cycle(1'b0, 1'b1, 5'd12, 32'h55, 1'b0, 5'd0, 1'b0, 32'd0);

        // Randomized traffic in phases with different pressure
        for (int p = 0; p < 3; p++) begin
            for (int k = 0; k < 400; k++) begin
                int apct;
                int lpct;
                int rpct;
                apct = (p == 0) ? 70 : (p == 1) ? 15 : 50;
                lpct = (p == 0) ? 40 : (p == 1) ? 75 : 50;
                rpct = (p == 0) ? 45 : (p == 1) ? 25 : 60;
                cycle(($urandom_range(0, 199) == 0),
                      ($urandom_range(0, 99) < apct), 5'($urandom_range(0, 31)), $urandom(),
                      ($urandom_range(0, 99) < lpct), 5'($urandom_range(0, 7)),
                      ($urandom_range(0, 99) < rpct), $urandom());
            end
        end
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
